zcheck_sweep_ctrl: RTL

Sequences impedance-check runs of the 2048-channel RHD interface controller over a channel range and a set of zcheck scales, with no software involvement per run. For each (channel, scale) pair it drives the controller's zcheck channel and scale inputs, issues a zcheck start pulse, and waits for completion. It then settles and advances to the next pair. It sits between the host register block and the RHD interface controller's zcheck_start / zcheck_global_channel / zcheck_scale inputs.

---
 rtl/zcheck_sweep_ctrl_if.sv | 45 ++++
 rtl/zcheck_sweep_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/zcheck_sweep_ctrl_if.sv
// zcheck_sweep_ctrl_if
// Groups the host-side sweep command/status signals and the RHD controller
// zcheck handshake used by zcheck_sweep_ctrl.
//   master : host / controller-model side (drives commands and zcheck_done)
//   slave  : the sweep controller itself
// Signals:
//   sweep_start, sweep_abort           host requests
//   first_channel, last_channel        inclusive channel range (12 bit)
//   scale_mask                         bit k set = run scale k
//   zcheck_done                        completion pulse from the controller
//   zcheck_start                       start pulse to the controller
//   zcheck_global_channel/zcheck_scale current run target
//   sweep_busy, sweep_done             sweep status
//   sweep_error, error_code            sticky error flag and cause
//   runs_completed                     zcheck_done pulses counted this sweep
interface zcheck_sweep_ctrl_if;
    logic        sweep_start;
    logic        sweep_abort;
    logic [11:0] first_channel;
    logic [11:0] last_channel;
    logic [3:0]  scale_mask;
    logic        zcheck_done;
    logic        zcheck_start;
    logic [11:0] zcheck_global_channel;
    logic [1:0]  zcheck_scale;
    logic        sweep_busy;
    logic        sweep_done;
    logic        sweep_error;
    logic [1:0]  error_code;
    logic [15:0] runs_completed;

    modport master (
        output sweep_start, sweep_abort, first_channel, last_channel,
               scale_mask, zcheck_done,
        input  zcheck_start, zcheck_global_channel, zcheck_scale,
               sweep_busy, sweep_done, sweep_error, error_code, runs_completed
    );

    modport slave (
        input  sweep_start, sweep_abort, first_channel, last_channel,
               scale_mask, zcheck_done,
        output zcheck_start, zcheck_global_channel, zcheck_scale,
               sweep_busy, sweep_done, sweep_error, error_code, runs_completed
    );
endinterface

// File: rtl/zcheck_sweep_ctrl.sv
// zcheck_sweep_ctrl
// Walks a channel range and a set of zcheck scales, issuing one zcheck run
// per (channel, scale) pair to the RHD interface controller. Scales iterate
// inside channels. Each run: start pulse, wait for zcheck_done (with
// timeout), settle, advance.
// Ports:
//   clk  - system clock
//   rstn - asynchronous reset, active-high (asserted = 1)
//   bus  - zcheck_sweep_ctrl_if.slave: host commands/status and the
//          zcheck_start / channel / scale / done handshake
module zcheck_sweep_ctrl #(
    parameter int NUM_CHANNELS       = 2048,
    parameter int START_PULSE_CYCLES = 10,
    parameter int SETTLE_CYCLES      = 64,
    parameter int TIMEOUT_CYCLES     = 2000000
) (
    input  logic               clk,
    input  logic               rstn,
    zcheck_sweep_ctrl_if.slave bus
);

    localparam logic [12:0] NUM_CH      = 13'(NUM_CHANNELS);
    localparam logic [31:0] PULSE_LAST  = 32'(START_PULSE_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TO_LAST     = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_LOAD, S_START, S_WAIT_DONE,
        S_SETTLE, S_ADVANCE, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [11:0] first_q, last_q, chan_q;
    logic [3:0]  mask_q;
    logic [1:0]  scale_q;
    logic        done_seen_q;
    logic        err_q;
    logic [1:0]  err_code_q;
    logic [15:0] runs_q;

    logic        accept, load, step, run_inc, err_set;
    logic [1:0]  err_code_d;
    logic [2:0]  higher;

    // Index of the lowest set bit; only used with a non-zero mask.
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        lowest_set = 2'd0;
        for (int k = 3; k >= 0; k--)
            if (m[k]) lowest_set = 2'(k);
    endfunction

    // {valid, index} of the next set bit strictly above cur.
    function automatic logic [2:0] next_set(input logic [3:0] m, input logic [1:0] cur);
        next_set = 3'b000;
        for (int k = 3; k >= 0; k--)
            if (m[k] && (k > int'(cur))) next_set = {1'b1, 2'(k)};
    endfunction

    assign higher = next_set(mask_q, scale_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        run_inc    = 1'b0;
        err_set    = 1'b0;
        err_code_d = 2'd0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.sweep_start) begin
                    accept  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((first_q > last_q) || ({1'b0, last_q} >= NUM_CH) || (mask_q == 4'd0)) begin
                    err_set    = 1'b1;
                    err_code_d = 2'd1;
                    state_d    = S_ERROR;
                end else begin
                    load    = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                // A done landing inside the pulse is counted; the pulse is
                // still completed, then WAIT_DONE is skipped.
                run_inc = bus.zcheck_done;
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = (done_seen_q || bus.zcheck_done) ? S_SETTLE : S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WAIT_DONE: begin
                if (bus.zcheck_done) begin
                    run_inc = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else if (cnt_q == TO_LAST) begin
                    err_set    = 1'b1;
                    err_code_d = 2'd2;
                    cnt_d      = '0;
                    state_d    = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ADVANCE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_ADVANCE: begin
                cnt_d = '0;
                if (higher[2] || (chan_q != last_q)) begin
                    step    = 1'b1;
                    state_d = S_START;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides every transition and every side effect.
        if (bus.sweep_abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            accept  = 1'b0;
            load    = 1'b0;
            step    = 1'b0;
            run_inc = 1'b0;
            err_set = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            first_q     <= '0;
            last_q      <= '0;
            mask_q      <= '0;
            chan_q      <= '0;
            scale_q     <= '0;
            done_seen_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            runs_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_seen_q <= (state_q == S_START) && (done_seen_q || bus.zcheck_done);
            if (accept) begin
                first_q    <= bus.first_channel;
                last_q     <= bus.last_channel;
                mask_q     <= bus.scale_mask;
                err_q      <= 1'b0;
                err_code_q <= 2'd0;
                runs_q     <= '0;
            end
            // Loaded on entry to LOAD so the target is stable a cycle
            // before zcheck_start rises.
            if (load) begin
                chan_q  <= first_q;
                scale_q <= lowest_set(mask_q);
            end
            if (step) begin
                if (higher[2]) begin
                    scale_q <= higher[1:0];
                end else begin
                    chan_q  <= chan_q + 12'd1;
                    scale_q <= lowest_set(mask_q);
                end
            end
            if (run_inc && (runs_q != 16'hFFFF))
                runs_q <= runs_q + 16'd1;
            if (err_set) begin
                err_q      <= 1'b1;
                err_code_q <= err_code_d;
            end
        end
    end

    // Decoded from state so reset drops zcheck_start asynchronously.
    assign bus.zcheck_start          = (state_q == S_START);
    assign bus.sweep_busy            = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    assign bus.sweep_done            = (state_q == S_DONE);
    assign bus.zcheck_global_channel = chan_q;
    assign bus.zcheck_scale          = scale_q;
    assign bus.sweep_error           = err_q;
    assign bus.error_code            = err_code_q;
    assign bus.runs_completed        = runs_q;

endmodule
